regfile_loader: RTL and testbench
=================================

# regfile_loader

Byte-stream loader and dumper for the 32×32 register file. It drives the register file's write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`) from a valid/ready byte stream, assembling big-endian words into consecutive registers. It also reads registers back through read port A and emits them as a byte stream. In the miner it loads the 80-byte block header (20 words) into registers and dumps it back for host verification.

## Interface
- `BASE_REG`, default 1: first target register. Legal range is 1..31; register 0 is hardwired zero.
- `WORD_COUNT`, default 20: words per load/dump. `BASE_REG+WORD_COUNT` must be ≤ 32.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `ctrl_reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin load; sampled only in IDLE.
- `dump`  in  1  begin readback; sampled only in IDLE.
- `in_byte`  in  8  load data byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `ctrl_writeEnable`  out  1  register-file write strobe.
- `ctrl_writeReg`  out  5  register-file write address.
- `data_writeReg`  out  32  register-file write data.
- `ctrl_readRegA`  out  5  register-file read address A.
- `data_readRegA`  in  32  register-file read data A (combinational from address).
- `out_byte`  out  8  dump data byte.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  consumer accepts `out_byte`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at end of load or dump.

## Operation
- **States:** IDLE, LOAD_COLLECT, LOAD_WRITE, DUMP_ADDR, DUMP_SEND, DONE.
- **IDLE:**
  - `start` → LOAD_COLLECT. Else `dump` → DUMP_ADDR. Both high: `start` wins.
  - Word index and byte count clear.
- **LOAD_COLLECT:**
  - `in_ready`=1. A byte is accepted when `in_valid & in_ready`.
  - Bytes are shifted into `data_writeReg`: first byte lands in [31:24], fourth in [7:0].
  - The 4th accepted byte moves the state to LOAD_WRITE.
- **LOAD_WRITE:**
  - For exactly one cycle: `in_ready`=0, `ctrl_writeEnable`=1, `ctrl_writeReg`=`BASE_REG`+index, `data_writeReg`=assembled word.
  - The register file captures the word on the following falling edge.
  - Index increments. If index was `WORD_COUNT`-1 → DONE, else → LOAD_COLLECT.
- **DUMP_ADDR:**
  - `ctrl_readRegA`=`BASE_REG`+index. At the edge, `data_readRegA` is latched into the 32-bit shift register → DUMP_SEND.
- **DUMP_SEND:**
  - `out_valid`=1, `out_byte`=shift[31:24].
  - On `out_valid & out_ready`: shift left 8 and count the byte.
  - After the 4th handshake, index increments. If the last word was sent → DONE, else → DUMP_ADDR.
- **DONE:** `done`=1 for one cycle → IDLE.
- `start`/`dump` outside IDLE are ignored.
- `ctrl_writeEnable` is 0 in every state except LOAD_WRITE.
- `ctrl_writeReg`, `data_writeReg` and `ctrl_readRegA` hold their last values outside active use.
- Address arithmetic is 5-bit. Parameter legality guarantees no wrap, and register 0 is never written.

## Timing
- **Reset (async, `ctrl_reset`=0):**
  - State → IDLE. All outputs clear: `in_ready`, `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`, `ctrl_readRegA`, `out_byte`, `out_valid`, `busy`, `done`.
  - Counters clear; a partial word is discarded.
  - `ctrl_writeEnable` drops immediately, so a reset during LOAD_WRITE aborts that write.
- **Start latency:** `start` at rising edge N gives `in_ready`=1 in cycle N+1.
- **Load throughput:** with `in_valid` held high, 5 cycles per word (4 accept + 1 write). 20 words take 100 cycles, then `done` in cycle 101 after entry.
- **Dump throughput:** with `out_ready` held high, 5 cycles per word (1 address + 4 send).
- **Backpressure:** `out_byte` must stay stable while `out_valid & !out_ready`. `in_valid` low simply stalls LOAD_COLLECT, with no timeout.
- **Last word:** `done` asserts the cycle after the final LOAD_WRITE or the final DUMP_SEND handshake. `busy` is high through DONE and low in the next cycle.

## Test plan
- **Reset values:** assert `ctrl_reset`=0 mid-sim → all outputs 0 the same cycle, state IDLE; after release `busy`=0.
- **Full load then dump:** load bytes 0x00..0x4F (`in_valid` constant) → registers 1..20 hold 0x00010203 … 0x4C4D4E4F, exactly 20 write strobes, `done` at cycle 101. Then `dump` → out stream 0x00..0x4F in order, `done` once.
- **Load stalls:** random `in_valid` gaps → same register contents; `ctrl_writeEnable` never asserted while `in_valid`=0 mid-word.
- **Dump backpressure:** random `out_ready` → `out_byte` stable while stalled; no byte lost or duplicated.
- **Simultaneous and ignored commands:** `start` & `dump` together → load runs. `dump` pulsed during load → ignored, no read activity.
- **Reset mid-word:** reset after 2 bytes of word 5 → registers 1..4 written, register 5 unchanged. A fresh `start` writes from register 1 again.

Source files
------------

// File: rtl/regfile_loader.sv
// Byte-stream loader/dumper for a 32x32 register file: packs big-endian bytes into
// consecutive registers through the write port and streams them back out through read port A.
module regfile_loader #(
  parameter int BASE_REG   = 1,
  parameter int WORD_COUNT = 20
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        start,
  input  logic        dump,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [4:0]  ctrl_readRegA,
  input  logic [31:0] data_readRegA,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_COLLECT, LOAD_WRITE, DUMP_ADDR, DUMP_SEND, DONE
  } state_t;

  localparam logic [4:0] BASE = 5'(BASE_REG);
  localparam logic [5:0] LAST = 6'(WORD_COUNT - 1);

  state_t      state, state_next;
  logic [5:0]  idx;
  logic [1:0]  cnt;
  logic [31:0] shift;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next       = state;
    in_ready         = 1'b0;
    ctrl_writeEnable = 1'b0;
    out_valid        = 1'b0;
    done             = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        if (start)     state_next = LOAD_COLLECT;
        else if (dump) state_next = DUMP_ADDR;
      end
      LOAD_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 2'd3) state_next = LOAD_WRITE;
      end
      LOAD_WRITE: begin
        ctrl_writeEnable = 1'b1;
        state_next = (idx == LAST) ? DONE : LOAD_COLLECT;
      end
      DUMP_ADDR: state_next = DUMP_SEND;
      DUMP_SEND: begin
        out_valid = 1'b1;
        if (out_ready && cnt == 2'd3) state_next = (idx == LAST) ? DONE : DUMP_ADDR;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write/read addresses are registered so they hold their last value between uses.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      idx           <= '0;
      cnt           <= '0;
      shift         <= '0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      ctrl_readRegA <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          cnt <= '0;
          if (!start && dump) ctrl_readRegA <= BASE;
        end
        LOAD_COLLECT: begin
          if (in_valid) begin
            data_writeReg <= {data_writeReg[23:0], in_byte};
            cnt           <= cnt + 2'd1;
            if (cnt == 2'd3) ctrl_writeReg <= BASE + idx[4:0];
          end
        end
        LOAD_WRITE: idx <= idx + 6'd1;
        DUMP_ADDR:  shift <= data_readRegA;
        DUMP_SEND: begin
          if (out_ready) begin
            shift <= {shift[23:0], 8'h00};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              idx           <= idx + 6'd1;
              ctrl_readRegA <= BASE + idx[4:0] + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_byte = shift[31:24];

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: models the register file, drives load/dump streams and
// compares against expected register contents derived from the byte stream.
module tb_regfile_loader;

  localparam int BASE = 1;
  localparam int WC   = 20;

  logic        clock, ctrl_reset, start, dump, in_valid, in_ready;
  logic [7:0]  in_byte, out_byte;
  logic        ctrl_writeEnable, out_valid, out_ready, busy, done;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA;
  logic [31:0] data_writeReg, data_readRegA;

  regfile_loader #(.BASE_REG(BASE), .WORD_COUNT(WC)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start), .dump(dump),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
    .data_readRegA(data_readRegA), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: captures writes on the falling edge, combinational read port A.
  logic [31:0] rf [32];
  logic        rf_init;
  always @(negedge clock) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hC0DE0000 | i);
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      rf[ctrl_writeReg] <= data_writeReg;
    end
  end
  assign data_readRegA = rf[ctrl_readRegA];

  logic [31:0] exp_rf [32];
  logic [7:0]  ld_bytes [80];
  int vectors, miscompares;

  typedef struct {
    logic s, d, iv;
    logic [7:0] b;
    logic [3:0] eflags;   // {busy, in_ready, ctrl_writeEnable, done}
    logic [4:0] ewreg;
    logic [31:0] ewdata;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " outputs in reset"},
        {in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA,
         out_byte, out_valid, busy, done}, 64'h0);
  endtask

  task automatic do_reset(input string tag);
    ctrl_reset = 1'b0;
    #1;
    check_zero(tag);
    start = 0; dump = 0; in_valid = 0; out_ready = 0;
    @(posedge clock);
    @(posedge clock);
    #1 ctrl_reset = 1'b1;
    step();
    chk({tag, " busy after release"}, busy, 0);
  endtask

  task automatic model_load(input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_rf[BASE + w] = {ld_bytes[4*w], ld_bytes[4*w+1], ld_bytes[4*w+2], ld_bytes[4*w+3]};
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 32; r++) chk($sformatf("%s reg%0d", tag, r), rf[r], exp_rf[r]);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 80; i++) ld_bytes[i] = 8'($urandom);
  endtask

  // Runs one load; returns early (without final checks) once abort_at bytes are accepted.
  task automatic run_load(input bit gaps, input bit dump_noise, input bit both,
                          input int abort_at, input string tag);
    int k, cyc, wes, we_bad, noise_bad, dones, done_cyc;
    bit prev_acc;
    logic [4:0] ra0;
    k = 0; wes = 0; we_bad = 0; noise_bad = 0; dones = 0; done_cyc = 0;
    prev_acc = 0; ra0 = ctrl_readRegA;
    start = 1; dump = both; in_valid = 0;
    step();
    start = 0; dump = 0;
    chk({tag, " in_ready after start"}, in_ready, 1);
    cyc = 1;
    while (dones == 0 && cyc <= 400) begin
      if (ctrl_writeEnable) begin
        wes++;
        if (!prev_acc) we_bad++;
      end
      if (out_valid || ctrl_readRegA !== ra0) noise_bad++;
      if (done) begin dones++; done_cyc = cyc; end
      if (abort_at >= 0 && k == abort_at) break;
      in_valid = gaps ? ($urandom_range(0, 99) < 60) : 1'b1;
      in_byte  = (k < 80) ? ld_bytes[k] : 8'h00;
      dump     = dump_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_acc = in_valid && in_ready;
      if (prev_acc) k++;
      step();
      cyc++;
    end
    dump = 0;
    if (abort_at >= 0) begin
      chk({tag, " bytes accepted before abort"}, k, abort_at);
      return;
    end
    in_valid = 0;
    chk({tag, " done pulses"}, dones, 1);
    chk({tag, " write strobes"}, wes, WC);
    chk({tag, " strobe without byte"}, we_bad, 0);
    chk({tag, " bytes consumed"}, k, 4 * WC);
    if (!gaps) chk({tag, " done cycle"}, done_cyc, 5 * WC + 1);
    if (dump_noise) chk({tag, " read activity during load"}, noise_bad, 0);
    step();
    chk({tag, " done/busy after DONE"}, {done, busy}, 2'b00);
    model_load(WC);
    check_rf(tag);
  endtask

  task automatic run_dump(input bit bp, input string tag);
    int cyc, dones, done_cyc, unstable, n;
    logic [7:0] got [$];
    logic [7:0] held, expb;
    bit stalled;
    dones = 0; done_cyc = 0; unstable = 0; stalled = 0; held = 0;
    dump = 1; start = 0;
    step();
    dump = 0;
    cyc = 1;
    while (dones == 0 && cyc <= 1000) begin
      if (stalled && (!out_valid || out_byte !== held)) unstable++;
      if (done) begin dones++; done_cyc = cyc; end
      out_ready = bp ? ($urandom_range(0, 99) < 50) : 1'b1;
      if (out_valid && out_ready) got.push_back(out_byte);
      stalled = out_valid && !out_ready;
      held    = out_byte;
      step();
      cyc++;
    end
    out_ready = 0;
    chk({tag, " dump done pulses"}, dones, 1);
    chk({tag, " byte count"}, got.size(), 4 * WC);
    chk({tag, " stall stability"}, unstable, 0);
    if (!bp) chk({tag, " dump done cycle"}, done_cyc, 5 * WC + 1);
    n = (got.size() < 4 * WC) ? got.size() : 4 * WC;
    for (int i = 0; i < n; i++) begin
      expb = exp_rf[BASE + i/4][31 - 8*(i%4) -: 8];
      chk($sformatf("%s byte%0d", tag, i), got[i], expb);
    end
    step();
    chk({tag, " busy after dump"}, busy, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    start = 0; dump = 0; in_valid = 0; in_byte = 0; out_ready = 0;
    ctrl_reset = 0; rf_init = 1;
    for (int i = 0; i < 32; i++) exp_rf[i] = (i == 0) ? 32'h0 : (32'hC0DE0000 | i);
    #1;
    check_zero("power-on");
    @(posedge clock); @(posedge clock);
    #1 rf_init = 0; ctrl_reset = 1;
    step();
    chk("busy after power-on release", busy, 0);

    //            s  d  iv  byte    {busy,rdy,we,done} wreg  wdata
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 5'd0, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'b1100, 5'd0, 32'h00000000};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'hAA, 4'b1100, 5'd0, 32'h000000AA};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h55, 4'b1100, 5'd0, 32'h000000AA};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'hBB, 4'b1100, 5'd0, 32'h0000AABB};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hCC, 4'b1100, 5'd0, 32'h00AABBCC};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'hDD, 4'b1010, 5'd1, 32'hAABBCCDD};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h11, 4'b1100, 5'd1, 32'hAABBCCDD};
    for (int v = 0; v < 8; v++) begin
      start = tbl[v].s; dump = tbl[v].d; in_valid = tbl[v].iv; in_byte = tbl[v].b;
      step();
      chk($sformatf("tbl%0d flags", v), {busy, in_ready, ctrl_writeEnable, done}, tbl[v].eflags);
      chk($sformatf("tbl%0d wreg", v), ctrl_writeReg, tbl[v].ewreg);
      chk($sformatf("tbl%0d wdata", v), data_writeReg, tbl[v].ewdata);
    end
    exp_rf[BASE] = 32'hAABBCCDD;
    do_reset("mid-load");
    check_rf("after table");

    for (int i = 0; i < 80; i++) ld_bytes[i] = 8'(i);
    run_load(0, 0, 0, -1, "full");
    run_dump(0, "full");

    fill_random();
    run_load(1, 0, 0, -1, "gaps");
    run_dump(1, "bp");

    fill_random();
    run_load(0, 1, 1, -1, "both");

    fill_random();
    run_load(1, 0, 0, 18, "abort");
    do_reset("mid-word");
    model_load(4);
    check_rf("abort");
    run_load(0, 0, 0, -1, "reload");

    fill_random();
    run_load(0, 0, 0, 4, "wr-abort");
    chk("write strobe before reset", ctrl_writeEnable, 1);
    do_reset("in write");
    check_rf("write aborted");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
